as_lookup_scheduler: RTL and testbench

Sequences the anti-spoof source-address check for each parsed packet. It captures {src_port, src_ip} on the rising edge of the Ethernet parser's ip_done and scans an internal permitted-source table, one entry per cycle. It issues a pass/drop verdict to the output stage. The table is shared with the register interface, and this block arbitrates between scans and software config accesses.

---
 rtl/as_lookup_scheduler_if.sv | 37 +++
 rtl/as_lookup_scheduler.sv | 131 +++++++++++++
 tb/tb_as_lookup_scheduler.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/as_lookup_scheduler_if.sv
// Packet, verdict, software-config and status signals of the anti-spoof lookup scheduler.
// The slave modport is the scheduler; the master side is the parser/register-block side.
interface as_lookup_scheduler_if #(
    parameter int NUM_IQ_BITS     = 3,
    parameter int TABLE_ADDR_BITS = 4,
    parameter int ENTRY_WIDTH     = 33 + NUM_IQ_BITS
);
    logic [31:0]                src_ip;
    logic [NUM_IQ_BITS-1:0]     src_port;
    logic                       ip_done;
    logic                       as_enable;
    logic                       verdict_vld;
    logic                       verdict_pass;
    logic                       cfg_req;
    logic                       cfg_wr;
    logic [TABLE_ADDR_BITS-1:0] cfg_addr;
    logic [ENTRY_WIDTH-1:0]     cfg_wdata;
    logic [ENTRY_WIDTH-1:0]     cfg_rdata;
    logic                       cfg_ack;
    logic [31:0]                pass_cnt;
    logic [31:0]                drop_cnt;
    logic                       lookup_overflow;

    modport master (
        output src_ip, src_port, ip_done, as_enable,
        output cfg_req, cfg_wr, cfg_addr, cfg_wdata,
        input  verdict_vld, verdict_pass, cfg_rdata, cfg_ack,
        input  pass_cnt, drop_cnt, lookup_overflow
    );

    modport slave (
        input  src_ip, src_port, ip_done, as_enable,
        input  cfg_req, cfg_wr, cfg_addr, cfg_wdata,
        output verdict_vld, verdict_pass, cfg_rdata, cfg_ack,
        output pass_cnt, drop_cnt, lookup_overflow
    );
endinterface

// File: rtl/as_lookup_scheduler.sv
// Anti-spoof source check: captures {port, ip} on ip_done rise, scans the permitted-source
// table one entry per cycle, and issues a pass/drop verdict; arbitrates table access with software.
module as_lookup_scheduler #(
    parameter int NUM_IQ_BITS     = 3,
    parameter int TABLE_ADDR_BITS = 4,
    parameter int TABLE_DEPTH     = 2 ** TABLE_ADDR_BITS,
    parameter int ENTRY_WIDTH     = 33 + NUM_IQ_BITS
) (
    input logic                  clk,
    input logic                  reset,
    as_lookup_scheduler_if.slave io_bus
);
    typedef enum logic [1:0] {IDLE, SCAN, RESULT, CFG} state_t;

    state_t                     r_state, w_next;
    logic                       r_ip_done_d;
    logic                       r_pending;
    logic [NUM_IQ_BITS-1:0]     r_pend_port, r_key_port;
    logic [31:0]                r_pend_ip, r_key_ip;
    logic                       r_bypass;
    logic                       r_pass;
    logic [TABLE_ADDR_BITS-1:0] r_idx;
    logic [ENTRY_WIDTH-1:0]     r_table [TABLE_DEPTH];
    logic [ENTRY_WIDTH-1:0]     r_cfg_rdata;
    logic                       r_cfg_ack;
    logic [31:0]                r_pass_cnt, r_drop_cnt;
    logic                       r_overflow;

    logic                       w_rise, w_start, w_hit, w_last;
    logic [ENTRY_WIDTH-1:0]     w_entry;

    assign w_rise  = io_bus.ip_done & ~r_ip_done_d;
    assign w_start = (r_state == IDLE) && r_pending;
    assign w_entry = r_table[r_idx];
    assign w_hit   = w_entry[ENTRY_WIDTH-1] &&
                     (w_entry[ENTRY_WIDTH-2:32] == r_key_port) &&
                     (w_entry[31:0] == r_key_ip);
    assign w_last  = (r_idx == TABLE_ADDR_BITS'(TABLE_DEPTH - 1));

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // A bypassed lookup still spends one SCAN cycle (without comparing) so that its
    // verdict lands on the same cycle as an entry-0 hit.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (r_pending)                                w_next = SCAN;
                else if (io_bus.cfg_req && !r_cfg_ack)        w_next = CFG;
            end
            SCAN:    if (r_bypass || w_hit || w_last)       w_next = RESULT;
            RESULT:                                         w_next = IDLE;
            CFG:                                            w_next = IDLE;
            default:                                        w_next = IDLE;
        endcase
    end

    always_comb begin
        io_bus.verdict_vld  = 1'b0;
        io_bus.verdict_pass = 1'b0;
        if (r_state == RESULT) begin
            io_bus.verdict_vld  = 1'b1;
            io_bus.verdict_pass = r_pass;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ip_done_d <= 1'b0;
            r_pending   <= 1'b0;
            r_pend_port <= '0;
            r_pend_ip   <= '0;
            r_key_port  <= '0;
            r_key_ip    <= '0;
            r_bypass    <= 1'b0;
            r_pass      <= 1'b0;
            r_idx       <= '0;
            r_cfg_rdata <= '0;
            r_cfg_ack   <= 1'b0;
            r_pass_cnt  <= '0;
            r_drop_cnt  <= '0;
            r_overflow  <= 1'b0;
            for (int i = 0; i < TABLE_DEPTH; i++) r_table[i] <= '0;
        end else begin
            r_ip_done_d <= io_bus.ip_done;
            r_cfg_ack   <= (r_state == CFG);

            // The scan key is copied out of the pending slot so a new capture can't disturb it.
            if (w_start) begin
                r_pending  <= 1'b0;
                r_key_port <= r_pend_port;
                r_key_ip   <= r_pend_ip;
                r_idx      <= '0;
                r_bypass   <= ~io_bus.as_enable;
            end
            if (w_rise) begin
                if (r_pending) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_pending   <= 1'b1;
                    r_pend_port <= io_bus.src_port;
                    r_pend_ip   <= io_bus.src_ip;
                end
            end

            if (r_state == SCAN) begin
                r_pass <= r_bypass | w_hit;
                r_idx  <= r_idx + 1'b1;
            end

            if (r_state == RESULT) begin
                if (r_pass) r_pass_cnt <= r_pass_cnt + 32'd1;
                else        r_drop_cnt <= r_drop_cnt + 32'd1;
            end

            if (r_state == CFG) begin
                if (io_bus.cfg_wr) r_table[io_bus.cfg_addr] <= io_bus.cfg_wdata;
                else               r_cfg_rdata              <= r_table[io_bus.cfg_addr];
            end
        end
    end

    assign io_bus.cfg_rdata       = r_cfg_rdata;
    assign io_bus.cfg_ack         = r_cfg_ack;
    assign io_bus.pass_cnt        = r_pass_cnt;
    assign io_bus.drop_cnt        = r_drop_cnt;
    assign io_bus.lookup_overflow = r_overflow;
endmodule

// File: tb/tb_as_lookup_scheduler.sv
// Scoreboard bench for as_lookup_scheduler: expected verdicts (pass bit + absolute cycle)
// are queued when a packet is driven and checked when verdict_vld fires.
module tb_as_lookup_scheduler;
    localparam int NIQ   = 3;
    localparam int AB    = 4;
    localparam int EW    = 33 + NIQ;
    localparam logic [31:0] IP_A = 32'h0A00_0005;
    localparam logic [31:0] IP_B = 32'hC0A8_0163;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    as_lookup_scheduler_if #(.NUM_IQ_BITS(NIQ), .TABLE_ADDR_BITS(AB)) bus ();

    as_lookup_scheduler #(.NUM_IQ_BITS(NIQ), .TABLE_ADDR_BITS(AB)) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus.slave)
    );

    typedef struct {
        logic pass;
        int   cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (bus.verdict_vld === 1'b1) begin
            chk("verdict_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("verdict_pass", 64'(bus.verdict_pass), 64'(e.pass));
                chk("verdict_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic wr, input logic [AB-1:0] a, input logic [EW-1:0] wd,
                       output logic [EW-1:0] rd, output int ack_cyc);
        int n;
        bus.cfg_req   = 1'b1;
        bus.cfg_wr    = wr;
        bus.cfg_addr  = a;
        bus.cfg_wdata = wd;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.cfg_ack !== 1'b1 && n < 200);
        chk("cfg_ack_seen", 64'(bus.cfg_ack), 64'd1);
        rd          = bus.cfg_rdata;
        ack_cyc     = cyc;
        bus.cfg_req = 1'b0;
    endtask

    // vcyc is the absolute cycle at which the verdict is expected.
    task automatic send(input logic [NIQ-1:0] p, input logic [31:0] ip, input bit push,
                        input logic pass, input int vcyc);
        bus.src_port = p;
        bus.src_ip   = ip;
        bus.ip_done  = 1'b1;
        if (push) sb.push_back('{pass, vcyc});
        tick();
        bus.ip_done = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk("sb_drained", 64'(sb.size()), 64'd0);
        tick();
    endtask

    logic [EW-1:0] rd;
    logic [EW-1:0] e3, e15;
    int            ac, n0;
    logic [31:0]   p0, d0;

    initial begin
        e3  = {1'b1, 3'd2, IP_A};
        e15 = {1'b1, 3'd5, IP_B};
        reset = 1'b1;
        bus.src_ip = '0; bus.src_port = '0; bus.ip_done = 1'b0; bus.as_enable = 1'b1;
        bus.cfg_req = 1'b0; bus.cfg_wr = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_verdict_vld", 64'(bus.verdict_vld), 64'd0);
        chk("rst_cfg_ack",     64'(bus.cfg_ack), 64'd0);
        chk("rst_pass_cnt",    64'(bus.pass_cnt), 64'd0);
        chk("rst_drop_cnt",    64'(bus.drop_cnt), 64'd0);
        chk("rst_overflow",    64'(bus.lookup_overflow), 64'd0);
        chk("rst_cfg_rdata",   64'(bus.cfg_rdata), 64'd0);

        // Hit at entry 3.
        cfg(1'b1, 4'd3, e3, rd, ac);
        send(3'd2, IP_A, 1'b1, 1'b1, cyc + 6);
        drain();
        chk("pass_cnt_hit", 64'(bus.pass_cnt), 64'd1);

        // Port mismatch: full miss.
        send(3'd1, IP_A, 1'b1, 1'b0, cyc + 18);
        drain();
        chk("drop_cnt_miss", 64'(bus.drop_cnt), 64'd1);

        // Hit at the last index.
        cfg(1'b1, 4'd15, e15, rd, ac);
        send(3'd5, IP_B, 1'b1, 1'b1, cyc + 18);
        drain();
        chk("pass_cnt_last", 64'(bus.pass_cnt), 64'd2);

        // Bypass with an empty table.
        cfg(1'b1, 4'd3, '0, rd, ac);
        cfg(1'b1, 4'd15, '0, rd, ac);
        bus.as_enable = 1'b0;
        p0 = bus.pass_cnt;
        for (int i = 0; i < 3; i++) begin
            send(3'(i), IP_B + 32'(i), 1'b1, 1'b1, cyc + 3);
            drain();
        end
        chk("pass_cnt_bypass", 64'(bus.pass_cnt - p0), 64'd3);
        bus.as_enable = 1'b1;

        // Empty table with the check enabled drops.
        send(3'd2, IP_A, 1'b1, 1'b0, cyc + 18);
        drain();
        cfg(1'b1, 4'd3, e3, rd, ac);

        // Lookup wins over a config read presented in the capture cycle.
        n0 = cyc;
        send(3'd2, IP_A, 1'b1, 1'b1, n0 + 6);
        cfg(1'b0, 4'd3, '0, rd, ac);
        chk("cfg_rdata_e3", 64'(rd), 64'(e3));
        chk("cfg_ack_cycle", 64'(ac), 64'(n0 + 9));
        drain();

        // Two rises during a full-miss scan: one pending, one lost.
        d0 = bus.drop_cnt;
        n0 = cyc;
        send(3'd1, IP_A, 1'b1, 1'b0, n0 + 18);
        repeat (3) tick();
        send(3'd1, IP_A, 1'b1, 1'b0, n0 + 36);
        repeat (2) tick();
        send(3'd1, IP_A, 1'b0, 1'b0, 0);
        drain();
        chk("overflow_set", 64'(bus.lookup_overflow), 64'd1);
        chk("drop_cnt_ovf", 64'(bus.drop_cnt - d0), 64'd2);

        // Reset mid-scan: no verdict, everything cleared.
        send(3'd1, IP_A, 1'b0, 1'b0, 0);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (20) tick();
        chk("rst2_pass_cnt", 64'(bus.pass_cnt), 64'd0);
        chk("rst2_drop_cnt", 64'(bus.drop_cnt), 64'd0);
        chk("rst2_overflow", 64'(bus.lookup_overflow), 64'd0);
        cfg(1'b0, 4'd3, '0, rd, ac);
        chk("rst2_entry3", 64'(rd), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
